core_test_ctrl: RTL

CORE_TEST_CTRL -- requirements
Module: core_test_ctrl

---
 rtl/core_test_pkg.sv | 23 ++
 rtl/imem_loader.sv | 31 +++
 rtl/core_test_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/core_test_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_test_pkg                                                        |
// | Shared state encoding and halt-store defaults for core_test_ctrl.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package core_test_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [31:0] C_HALT_ADDR = 32'hFFFC;
    localparam int unsigned C_PASS_VAL  = 1;

    function automatic logic is_busy(input logic [2:0] st);
        return (st == ST_LOAD) || (st == ST_HOLD) || (st == ST_RUN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader                                                          |
// | Turns the program-load stream into instruction-memory writes.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imem_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              active,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic [ADDR_W-1:0] wptr,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              final_beat
);

    assign ld_ready   = active;
    assign imem_we    = active & ld_valid;
    assign imem_waddr = wptr;
    assign imem_wdata = ld_data;
    // Writing the top word ends the load even without ld_last, so the pointer never wraps.
    assign final_beat = imem_we & (ld_last | (&wptr));

endmodule
`default_nettype wire

// File: rtl/core_test_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_test_ctrl                                                       |
// | Loads a program, holds the core in reset, runs it and grades the     |
// | halt store (or timeout).                                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module core_test_ctrl
    import core_test_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 8,
    parameter int unsigned TIMEOUT   = 1000,
    parameter int unsigned RST_HOLD  = 2,
    parameter logic [31:0] HALT_ADDR = C_HALT_ADDR,
    parameter int unsigned PASS_VAL  = C_PASS_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    input  logic              dmem_we,
    input  logic [31:0]       dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [31:0]       cycle_count,
    output logic [ADDR_W:0]   load_count
);

    localparam int unsigned       C_HOLD      = (RST_HOLD == 0) ? 1 : RST_HOLD;
    localparam logic [31:0]       C_HOLD_LAST = 32'(C_HOLD - 1);
    localparam logic [31:0]       C_TIMEOUT   = 32'(TIMEOUT);
    localparam logic [DATA_W-1:0] C_PASS      = DATA_W'(PASS_VAL);
    localparam logic [ADDR_W:0]   C_LOAD_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]      r_state;
    logic [31:0]     r_hold_cnt;
    logic [31:0]     r_cycle_cnt;
    logic [ADDR_W:0] r_load_cnt;
    logic            r_done;
    logic            r_pass;
    logic            r_timeout;

    logic            w_final;
    logic            w_halt;
    logic [31:0]     w_cc_next;

    imem_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .active     (r_state == ST_LOAD),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .wptr       (r_load_cnt[ADDR_W-1:0]),
        .ld_ready   (ld_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .final_beat (w_final)
    );

    assign w_halt    = dmem_we && (dmem_addr == HALT_ADDR);
    assign w_cc_next = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_hold_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_load_cnt  <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_LOAD;
                        r_cycle_cnt <= '0;
                        r_load_cnt  <= '0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (imem_we) begin
                        r_load_cnt <= r_load_cnt + C_LOAD_ONE;
                        if (w_final) begin
                            r_state    <= ST_HOLD;
                            r_hold_cnt <= '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == C_HOLD_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 32'd1;
                    end
                end
                ST_RUN: begin
                    r_cycle_cnt <= w_cc_next;
                    // A halt store beats a coinciding timeout.
                    if (w_halt) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (dmem_wdata == C_PASS);
                    end else if (w_cc_next >= C_TIMEOUT) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign core_rst    = (r_state != ST_RUN);
    assign busy        = is_busy(r_state);
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_cnt;
    assign load_count  = r_load_cnt;

endmodule
`default_nettype wire
